// File: rtl/relu_fwd_mask.sv
// Forward ReLU stage for 14-bit FloPoCo words that records a clamp mask per element and replays it in forward order.
// Optional build macro RELU_NAN_PASS_EN: NaN words pass through unclamped with mask 0.
module relu_fwd_mask #(
    parameter int BITWIDTH = 12,
    parameter int BW       = BITWIDTH + 2 - 1,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fwd_valid,
    input  logic [BW:0]   fwd_in,
    output logic          fwd_ready,
    output logic          fwd_out_valid,
    output logic [BW:0]   fwd_out,
    input  logic          bwd_start,
    input  logic          bwd_ready,
    output logic          mask_valid,
    output logic          mask_out,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          done
);

    typedef enum logic [1:0] {FWD, BWD, FIN} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state, state_nxt;
    logic [AW:0] rd_ptr;
    logic        mask_mem [DEPTH];

    logic [1:0]  exn;
    logic        sign;
    logic        clamp;
    logic        accept;
    logic        drop;
    logic        go_bwd;
    logic        xfer;
    logic        last_xfer;
    logic        load;

    assign exn  = fwd_in[BW:BW-1];
    assign sign = fwd_in[BW-2];

`ifdef RELU_NAN_PASS_EN
    assign clamp = (exn != 2'b11) && (sign || (exn == 2'b00));
`else
    assign clamp = sign || (exn == 2'b00);
`endif

    assign fwd_ready = (state == FWD) && (count < FULL);
    assign accept    = enable && fwd_valid && fwd_ready;
    assign drop      = enable && fwd_valid && (state == FWD) && (count == FULL);
    assign go_bwd    = enable && bwd_start && (state == FWD) && ((count != '0) || accept);

    // rd_ptr advances on each load, so rd_ptr==count while valid marks the final bit.
    assign xfer      = (state == BWD) && mask_valid && bwd_ready;
    assign last_xfer = xfer && (rd_ptr == count);
    assign load      = (state == BWD) && (!mask_valid || bwd_ready) && (rd_ptr != count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FWD;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FWD:     if (go_bwd) state_nxt = BWD;
            BWD:     if (last_xfer) state_nxt = FIN;
            FIN:     state_nxt = FWD;
            default: state_nxt = FWD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mask_mem[count[AW-1:0]] <= clamp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_out_valid <= 1'b0;
            fwd_out       <= '0;
            mask_valid    <= 1'b0;
            mask_out      <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            done          <= 1'b0;
        end else if (enable) begin
            fwd_out_valid <= accept;
            done          <= last_xfer;
            if (accept) begin
                fwd_out <= clamp ? '0 : fwd_in;
                count   <= count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (go_bwd) begin
                rd_ptr     <= '0;
                mask_valid <= 1'b0;
            end
            if (last_xfer) begin
                mask_valid <= 1'b0;
                mask_out   <= 1'b0;
                count      <= '0;
            end else if (load) begin
                mask_out   <= mask_mem[rd_ptr[AW-1:0]];
                mask_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relu_fwd_mask.sv
// Self-checking bench for relu_fwd_mask: random words against a field-level ReLU model and a mask queue.
module tb_relu_fwd_mask;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fwd_valid;
    logic [13:0] fwd_in;
    logic        fwd_ready;
    logic        fwd_out_valid;
    logic [13:0] fwd_out;
    logic        bwd_start;
    logic        bwd_ready;
    logic        mask_valid;
    logic        mask_out;
    logic [6:0]  count;
    logic        overflow;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    relu_fwd_mask dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
        .fwd_out_valid(fwd_out_valid), .fwd_out(fwd_out),
        .bwd_start(bwd_start), .bwd_ready(bwd_ready),
        .mask_valid(mask_valid), .mask_out(mask_out),
        .count(count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    // Returns {mask, result}: negative numbers and zeros become 0.
    function automatic logic [14:0] ref_relu(input logic [13:0] w);
        int  exn;
        bit  neg;
        bit  kill;
        exn  = int'(w[13:12]);
        neg  = w[11];
        kill = neg || (exn == 0);
`ifdef RELU_NAN_PASS_EN
        if (exn == 3) kill = 1'b0;
`endif
        return kill ? {1'b1, 14'h0000} : {1'b0, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] w);
        logic [14:0] r;
        int k;
        r = ref_relu(w);
        k = 0;
        while (fwd_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (fwd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready got %b expected 1", fwd_ready);
        end
        fwd_valid = 1'b1;
        fwd_in    = w;
        step();
        fwd_valid = 1'b0;
        checks++;
        if (fwd_out_valid !== 1'b1 || fwd_out !== r[13:0]) begin
            errors++;
            $display("FAIL fwd_out in=%h got v=%b %h expected v=1 %h", w, fwd_out_valid, fwd_out, r[13:0]);
        end
        exp_q.push_back(r[14]);
    endtask

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready
    task automatic replay(input int mode);
        int  n, got, cyc;
        bit  seen_valid, prev_stall, prev_bit, finished;
        n = exp_q.size();
        got = 0;
        seen_valid = 0;
        prev_stall = 0;
        prev_bit = 0;
        finished = 0;
        bwd_start = 1'b1;
        bwd_ready = 1'b1;
        step();
        bwd_start = 1'b0;
        for (cyc = 0; cyc < 1000 && !finished; cyc++) begin
            case (mode)
                0:       bwd_ready = 1'b1;
                1:       bwd_ready = (cyc % 3 == 0);
                default: bwd_ready = 1'($urandom_range(0, 1));
            endcase
            if (fwd_ready !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL replay_fwd_ready got %b expected 0", fwd_ready);
            end
            if (prev_stall) begin
                checks++;
                if (mask_valid !== 1'b1 || mask_out !== prev_bit) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b b=%b expected v=1 b=%b", mask_valid, mask_out, prev_bit);
                end
            end
            if (mode == 0 && seen_valid && got < n && mask_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL no_bubble got mask_valid 0 expected 1 at bit %0d", got);
            end
            if (mask_valid === 1'b1) seen_valid = 1;
            prev_stall = (mask_valid === 1'b1) && !bwd_ready;
            prev_bit   = mask_out;
            if (mask_valid === 1'b1 && bwd_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_bit got %b expected none", mask_out);
                end else if (mask_out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mask_bit %0d got %b expected %b", got, mask_out, exp_q[0]);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
                step();
                if (got == n) begin
                    checks++;
                    if (done !== 1'b1 || count !== 7'd0) begin
                        errors++;
                        $display("FAIL done_pulse got done=%b count=%0d expected done=1 count=0", done, count);
                    end
                    finished = 1;
                end
            end else begin
                step();
                if (done === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL early_done got done=1 after %0d of %0d bits", got, n);
                    finished = 1;
                end
            end
        end
        bwd_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL replay_len got %0d expected %0d", got, n);
        end
        step();
        checks++;
        if (done !== 1'b0 || mask_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_single got done=%b mask_valid=%b expected 0 0", done, mask_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (fwd_out_valid !== 0 || fwd_out !== 0 || mask_valid !== 0 || mask_out !== 0 ||
            count !== 0 || overflow !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b o=%h mv=%b m=%b c=%0d of=%b d=%b expected all 0",
                     fwd_out_valid, fwd_out, mask_valid, mask_out, count, overflow, done);
        end
        bwd_start = 1'b1;
        step();
        bwd_start = 1'b0;
        step();
        step();
        checks++;
        if (fwd_ready !== 1'b1 || mask_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL empty_start got ready=%b mv=%b done=%b expected 1 0 0", fwd_ready, mask_valid, done);
        end
    endtask

    task automatic test_basic();
        push(14'h1380);
        push(14'h1B80);
        push(14'h0000);
        push(14'h2000);
        checks++;
        if (fwd_out_valid !== 1'b1 || fwd_out !== 14'h2000 || count !== 7'd4) begin
            errors++;
            $display("FAIL basic_tail got v=%b o=%h c=%0d expected 1 2000 4", fwd_out_valid, fwd_out, count);
        end
        step();
        checks++;
        if (fwd_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_drop got %b expected 0", fwd_out_valid);
        end
        replay(0);
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 12; i++) push(14'($urandom_range(0, 16383)));
        replay(1);
    endtask

    task automatic test_nan();
        push(14'h3800);
        push(14'h1380);
        replay(0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 64; i++) push(14'($urandom_range(0, 16383)));
        checks++;
        if (fwd_ready !== 1'b0 || count !== 7'd64) begin
            errors++;
            $display("FAIL full got ready=%b count=%0d expected 0 64", fwd_ready, count);
        end
        fwd_valid = 1'b1;
        fwd_in    = 14'h1380;
        step();
        fwd_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fwd_out_valid !== 1'b0 || count !== 7'd64) begin
            errors++;
            $display("FAIL overflow got of=%b ov=%b c=%0d expected 1 0 64", overflow, fwd_out_valid, count);
        end
        replay(2);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_enable_reset();
        logic        s_mv, s_m, s_ov, s_d;
        logic [6:0]  s_c;
        logic [13:0] s_o;
        for (int i = 0; i < 5; i++) push(14'($urandom_range(0, 16383)));
        bwd_start = 1'b1;
        bwd_ready = 1'b0;
        step();
        bwd_start = 1'b0;
        step();
        step();
        enable = 1'b0;
        bwd_ready = 1'b1;
        s_mv = mask_valid; s_m = mask_out; s_ov = fwd_out_valid;
        s_d = done; s_c = count; s_o = fwd_out;
        for (int i = 0; i < 3; i++) begin
            bwd_start = 1'(i & 1);
            step();
            checks++;
            if (mask_valid !== s_mv || mask_out !== s_m || fwd_out_valid !== s_ov ||
                done !== s_d || count !== s_c || fwd_out !== s_o) begin
                errors++;
                $display("FAIL freeze got mv=%b m=%b c=%0d expected mv=%b m=%b c=%0d",
                         mask_valid, mask_out, count, s_mv, s_m, s_c);
            end
        end
        bwd_start = 1'b0;
        bwd_ready = 1'b0;
        enable = 1'b1;
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (mask_valid !== 0 || mask_out !== 0 || count !== 0 || overflow !== 0 ||
            done !== 0 || fwd_out_valid !== 0 || fwd_out !== 0) begin
            errors++;
            $display("FAIL mid_reset got mv=%b m=%b c=%0d of=%b d=%b expected all 0",
                     mask_valid, mask_out, count, overflow, done);
        end
        step();
        rst = 1'b0;
        bwd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || mask_valid !== 1'b0 || fwd_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset got done=%b mv=%b ready=%b expected 0 0 1", done, mask_valid, fwd_ready);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        fwd_valid = 1'b0;
        fwd_in = '0;
        bwd_start = 1'b0;
        bwd_ready = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_random_stall();
        test_nan();
        test_overflow();
        test_enable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
